// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command engine: opcodes, FSM state
// encoding, the byte returned while discarding, and the status byte format.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;
    localparam logic [7:0] OP_STATUS_CLR = 8'h03;
    localparam logic [7:0] DISCARD_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_ADDR = 3'd1,
        WDATA    = 3'd2,
        RDUMMY   = 3'd3,
        RDATA    = 3'd4,
        DISCARD  = 3'd5
    } state_t;

    // Status byte: constant ID nibble, two reserved zeros, sticky error flags.
    function automatic logic [7:0] status_byte(input logic [3:0] id,
                                               input logic       abort_err,
                                               input logic       op_err);
        return {id, 2'b00, abort_err, op_err};
    endfunction

endpackage

// File: rtl/spi_cmd_engine_sync2.sv
// Two-flop synchronizer for a single asynchronous level (used for SPI ss).
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset; output resets to 1 (ss inactive)
//   d   - asynchronous input level
//   q   - synchronized level
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage synchronizer chain, idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            q_r    <= 1'b1;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/spi_cmd_engine.sv
// Byte-level command engine behind an SPI slave byte shifter. Decodes
// opcode / address / payload frames, drives a register-file port for writes
// and auto-incrementing prefetched burst reads, and supplies the next MISO byte.
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   ss                - raw active-low slave select (synchronized here)
//   rx_valid, rx_byte - one-clk pulse with a received MOSI byte
//   tx_byte           - byte to shift out on the next transfer
//   reg_addr, reg_wr, reg_wdata, reg_rd, reg_rdata - register-file port
//   busy              - frame active (synchronized ss low)
module spi_cmd_engine
    import spi_cmd_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [3:0] STATUS_ID = 4'hA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              ss_sync_s, ss_prev_r, frame_end_s, byte_s;
    state_t            state_r, state_next_s;
    logic [7:0]        tx_byte_r, tx_next_s, reg_wdata_r, wdata_next_s, prefetch_r;
    logic [ADDR_W-1:0] reg_addr_r, addr_next_s;
    logic              reg_wr_r, wr_next_s, reg_rd_r, rd_next_s, rd_pend_r;
    logic              op_err_r, op_err_next_s, abort_err_r, abort_next_s;
    logic              clr_pending_r, clr_next_s, cmd_rd_r, cmd_rd_next_s, load_tx_s;

    sync2 u_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (ss),
        .q   (ss_sync_s)
    );

    // Frame end takes priority: on the rising edge ss_sync_s is already high,
    // so a coincident rx_valid is masked out of byte_s.
    assign frame_end_s = ss_sync_s & ~ss_prev_r;
    assign byte_s      = rx_valid & ~ss_sync_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_next_s  = state_r;
        wdata_next_s  = reg_wdata_r;
        wr_next_s     = 1'b0;
        rd_next_s     = 1'b0;
        op_err_next_s = op_err_r;
        abort_next_s  = abort_err_r;
        clr_next_s    = clr_pending_r;
        cmd_rd_next_s = cmd_rd_r;
        load_tx_s     = 1'b0;
        tx_next_s     = tx_byte_r;

        // A write strobe is followed by the address step on the edge that drops it.
        if (reg_wr_r) begin
            addr_next_s = reg_addr_r + ADDR_ONE;
        end else begin
            addr_next_s = reg_addr_r;
        end

        if (frame_end_s) begin
            state_next_s = IDLE;
            clr_next_s   = 1'b0;
            // Abort setting wins over a pending clear in the same cycle.
            if (state_r == CMD_ADDR) begin
                abort_next_s = 1'b1;
            end else if (clr_pending_r) begin
                op_err_next_s = 1'b0;
                abort_next_s  = 1'b0;
            end else begin
                abort_next_s = abort_err_r;
            end
        end else if (byte_s) begin
            case (state_r)
                IDLE: begin
                    case (rx_byte)
                        OP_WRITE, OP_READ: begin
                            state_next_s  = CMD_ADDR;
                            cmd_rd_next_s = (rx_byte == OP_READ);
                        end
                        OP_STATUS_CLR: begin
                            state_next_s = DISCARD;
                            clr_next_s   = 1'b1;
                        end
                        default: begin
                            state_next_s  = DISCARD;
                            op_err_next_s = 1'b1;
                        end
                    endcase
                end
                CMD_ADDR: begin
                    addr_next_s = rx_byte[ADDR_W-1:0];
                    if (cmd_rd_r) begin
                        state_next_s = RDUMMY;
                        rd_next_s    = 1'b1;
                    end else begin
                        state_next_s = WDATA;
                    end
                end
                WDATA: begin
                    wdata_next_s = rx_byte;
                    wr_next_s    = 1'b1;
                end
                RDUMMY, RDATA: begin
                    // Hand out the prefetched byte and fetch the one after it.
                    state_next_s = RDATA;
                    addr_next_s  = reg_addr_r + ADDR_ONE;
                    rd_next_s    = 1'b1;
                    load_tx_s    = 1'b1;
                end
                DISCARD: begin
                    state_next_s = DISCARD;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end

        case (state_next_s)
            IDLE, CMD_ADDR, RDUMMY: tx_next_s = status_byte(STATUS_ID, abort_next_s, op_err_next_s);
            DISCARD:                tx_next_s = DISCARD_BYTE;
            RDATA: begin
                if (load_tx_s) begin
                    tx_next_s = prefetch_r;
                end else begin
                    tx_next_s = tx_byte_r;
                end
            end
            default:                tx_next_s = status_byte(STATUS_ID, abort_next_s, op_err_next_s);
        endcase
    end

    // Registered outputs, sticky flags and the read prefetch pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_prev_r     <= 1'b1;
            tx_byte_r     <= {STATUS_ID, 4'h0};
            reg_addr_r    <= {ADDR_W{1'b0}};
            reg_wr_r      <= 1'b0;
            reg_wdata_r   <= 8'h00;
            reg_rd_r      <= 1'b0;
            rd_pend_r     <= 1'b0;
            prefetch_r    <= 8'h00;
            op_err_r      <= 1'b0;
            abort_err_r   <= 1'b0;
            clr_pending_r <= 1'b0;
            cmd_rd_r      <= 1'b0;
        end else begin
            ss_prev_r     <= ss_sync_s;
            tx_byte_r     <= tx_next_s;
            reg_addr_r    <= addr_next_s;
            reg_wr_r      <= wr_next_s;
            reg_wdata_r   <= wdata_next_s;
            reg_rd_r      <= rd_next_s;
            rd_pend_r     <= reg_rd_r;
            // reg_rdata is valid in the cycle after reg_rd.
            if (rd_pend_r) begin
                prefetch_r <= reg_rdata;
            end else begin
                prefetch_r <= prefetch_r;
            end
            op_err_r      <= op_err_next_s;
            abort_err_r   <= abort_next_s;
            clr_pending_r <= clr_next_s;
            cmd_rd_r      <= cmd_rd_next_s;
        end
    end

    assign tx_byte   = tx_byte_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wr    = reg_wr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_rd    = reg_rd_r;
    assign busy      = ~ss_sync_s;

endmodule

// File: tb/tb_spi_cmd_engine.sv
module tb_spi_cmd_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic [5:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int rd_count = 0;
    logic [5:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    logic [7:0] regs [64];
    logic [7:0] rdata_q = 8'h00;
    logic [7:0] miso;
    int wr_base;
    int rd_base;

    always #5 clk = ~clk;

    spi_cmd_engine dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    assign reg_rdata = rdata_q;

    // Register-file model with one-cycle read latency, plus strobe logging.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
        end else begin
            if (reg_wr) begin
                regs[reg_addr] <= reg_wdata;
                if (wr_count < 16) begin
                    wr_addr_log[wr_count] = reg_addr;
                    wr_data_log[wr_count] = reg_wdata;
                end
                wr_count = wr_count + 1;
            end
            if (reg_rd) begin
                rdata_q <= regs[reg_addr];
                rd_count = rd_count + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SPI byte: MISO is what the engine presents at the start of the
    // transfer; rx_valid pulses when the byte completes.
    task automatic xfer(input logic [7:0] mosi, output logic [7:0] so);
        @(negedge clk);
        so = tx_byte;
        repeat (6) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = mosi;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ss_high();
        ss = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {24'h0, tx_byte}, 32'hA0);
        check("rst_addr", {26'h0, reg_addr}, 32'h0);
        check("rst_wr", {31'h0, reg_wr}, 32'h0);
        check("rst_wdata", {24'h0, reg_wdata}, 32'h0);
        check("rst_rd", {31'h0, reg_rd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write frame 01 05 AA BB
        ss_low();
        check("busy_frame", {31'h0, busy}, 32'h1);
        xfer(8'h01, miso); check("wr_miso0", {24'h0, miso}, 32'hA0);
        xfer(8'h05, miso); check("wr_miso1", {24'h0, miso}, 32'hA0);
        xfer(8'hAA, miso);
        xfer(8'hBB, miso);
        ss_high();
        check("wr_count", wr_count, 32'd2);
        check("wr0_addr", {26'h0, wr_addr_log[0]}, 32'h05);
        check("wr0_data", {24'h0, wr_data_log[0]}, 32'hAA);
        check("wr1_addr", {26'h0, wr_addr_log[1]}, 32'h06);
        check("wr1_data", {24'h0, wr_data_log[1]}, 32'hBB);
        check("wr_rd_none", rd_count, 32'd0);

        // Preload 3F=11, 00=22 with a wrapping write
        ss_low();
        xfer(8'h01, miso); xfer(8'h3F, miso); xfer(8'h11, miso); xfer(8'h22, miso);
        ss_high();
        check("wrap_wr_addr", {26'h0, wr_addr_log[3]}, 32'h00);
        check("wrap_wr_data", {24'h0, wr_data_log[3]}, 32'h22);

        // Burst read 02 3F 00 00 00
        wr_base = wr_count;
        ss_low();
        xfer(8'h02, miso); check("rd_miso0", {24'h0, miso}, 32'hA0);
        xfer(8'h3F, miso); check("rd_miso1", {24'h0, miso}, 32'hA0);
        xfer(8'h00, miso); check("rd_miso2", {24'h0, miso}, 32'hA0);
        xfer(8'h00, miso); check("rd_miso3", {24'h0, miso}, 32'h11);
        xfer(8'h00, miso); check("rd_miso4", {24'h0, miso}, 32'h22);
        ss_high();
        check("rd_count", rd_count, 32'd4);
        check("rd_addr_end", {26'h0, reg_addr}, 32'h02);
        check("rd_no_wr", wr_count, wr_base);

        // Bad opcode 7E 12 34
        wr_base = wr_count;
        rd_base = rd_count;
        ss_low();
        xfer(8'h7E, miso); check("bad_miso0", {24'h0, miso}, 32'hA0);
        xfer(8'h12, miso); check("bad_miso1", {24'h0, miso}, 32'hFF);
        xfer(8'h34, miso); check("bad_miso2", {24'h0, miso}, 32'hFF);
        ss_high();
        check("bad_no_wr", wr_count, wr_base);
        check("bad_no_rd", rd_count, rd_base);
        check("bad_status", {24'h0, tx_byte}, 32'hA1);

        // Status clear
        ss_low();
        xfer(8'h03, miso); check("clr1_miso0", {24'h0, miso}, 32'hA1);
        xfer(8'h55, miso); check("clr1_miso1", {24'h0, miso}, 32'hFF);
        ss_high();
        check("clr1_status", {24'h0, tx_byte}, 32'hA0);

        // Abort in CMD_ADDR, then clear
        ss_low();
        xfer(8'h01, miso);
        ss_high();
        check("abort_status", {24'h0, tx_byte}, 32'hA2);
        ss_low();
        xfer(8'h03, miso); check("clr2_miso0", {24'h0, miso}, 32'hA2);
        ss_high();
        check("clr2_status", {24'h0, tx_byte}, 32'hA0);

        // rx_valid coincident with synchronized ss rise: byte dropped
        ss_low();
        xfer(8'h01, miso); xfer(8'h10, miso);
        wr_base = wr_count;
        ss = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("simul_no_wr", wr_count, wr_base);
        check("simul_status", {24'h0, tx_byte}, 32'hA0);

        // Async reset during a write strobe
        ss_low();
        xfer(8'h01, miso); xfer(8'h20, miso);
        repeat (5) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("pre_rst_wr", {31'h0, reg_wr}, 32'h1);
        wr_base = wr_count;
        rd_base = rd_count;
        rst = 1'b1;
        #1;
        check("mid_rst_wr", {31'h0, reg_wr}, 32'h0);
        check("mid_rst_addr", {26'h0, reg_addr}, 32'h0);
        check("mid_rst_wdata", {24'h0, reg_wdata}, 32'h0);
        check("mid_rst_tx", {24'h0, tx_byte}, 32'hA0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_wr", wr_count, wr_base);
        check("post_rst_rd", rd_count, rd_base);
        check("post_rst_busy", {31'h0, busy}, 32'h1);
        ss_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
